// File: rtl/adc_sample_ctrl.sv
// Periodic two-channel ADC sequencer: issues conversion starts, accumulates
// 2^AVG_LOG2 sample pairs, and presents their floor average on a valid/ready port.
module adc_sample_ctrl #(
  parameter int PERIOD   = 100,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        conv,
  input  logic        end_conv,
  input  logic [13:0] ch0_in,
  input  logic [13:0] ch1_in,
  output logic [13:0] avg0_out,
  output logic [13:0] avg1_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clr_err
);

  localparam int AW = 14 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int NS = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          per_q, per_d;
  logic [9:0]           tmo_q, tmo_d;
  logic                 ec_q;
  logic signed [AW-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic signed [AW-1:0] samp0, samp1, sum0, sum1;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [13:0]          avg0_q, avg0_d, avg1_q, avg1_d;
  logic                 ovr_q, ovr_d, terr_q, terr_d;
  logic                 ovr_set, terr_set;
  logic                 tick, rise, per_last;

  assign per_last = (per_q == 16'(PERIOD - 1));
  assign tick     = enable && per_last;
  assign rise     = end_conv && !ec_q;

  // Sign-extend each result to the accumulator width before adding.
  assign samp0 = AW'($signed(ch0_in));
  assign samp1 = AW'($signed(ch1_in));
  assign sum0  = acc0_q + samp0;
  assign sum1  = acc1_q + samp1;

  always_comb begin
    if (!enable)       per_d = '0;
    else if (per_last) per_d = '0;
    else               per_d = per_q + 16'd1;
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    cnt_d    = cnt_q;
    avg0_d   = avg0_q;
    avg1_d   = avg1_q;
    ovr_set  = 1'b0;
    terr_set = 1'b0;
    conv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          conv    = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        ovr_set = tick;
        if (rise) begin
          acc0_d = sum0;
          acc1_d = sum1;
          cnt_d  = CW'(cnt_q + 1'b1);
          if (cnt_q == CW'(NS - 1)) begin
            avg0_d  = 14'(sum0 >>> AVG_LOG2);
            avg1_d  = 14'(sum1 >>> AVG_LOG2);
            state_d = S_OUT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tmo_q == 10'(TIMEOUT - 1)) begin
          // Lost conversion: drop the whole partial batch.
          terr_set = 1'b1;
          acc0_d   = '0;
          acc1_d   = '0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      S_OUT: begin
        ovr_set = tick;
        if (out_ready) begin
          acc0_d  = '0;
          acc1_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set has priority over a coincident clear.
  assign ovr_d  = ovr_set  ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
  assign terr_d = terr_set ? 1'b1 : (clr_err ? 1'b0 : terr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      tmo_q   <= '0;
      ec_q    <= 1'b0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      cnt_q   <= '0;
      avg0_q  <= '0;
      avg1_q  <= '0;
      ovr_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      ec_q    <= end_conv;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      cnt_q   <= cnt_d;
      avg0_q  <= avg0_d;
      avg1_q  <= avg1_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
    end
  end

  assign out_valid   = (state_q == S_OUT);
  assign avg0_out    = avg0_q;
  assign avg1_out    = avg1_q;
  assign overrun     = ovr_q;
  assign timeout_err = terr_q;

endmodule
